// File: rtl/facto_core.sv
// facto_core: memory-mapped 128-bit factorial engine (shift-add multiplier).
// Ports: clk, reset_n, s_sel/s_wr/s_addr/s_din/s_dout bus, interrupt.
module facto_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           opstart_q;
  logic           opclear_q;
  logic           intr_en_q;
  logic [63:0]    operand_q;
  logic [127:0]   result_q, result_d;
  logic [63:0]    count_q, count_d;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   mcand_q, mcand_d;
  logic [63:0]    mplier_q, mplier_d;
  logic [63:0]    cnt_dec;
  logic [1:0]     opdone;
  logic [4:0]     reg_idx;
  logic           wr_en;
  logic           we_start;
  logic           we_clear;
  logic           we_ien;
  logic           we_opnd;
  logic           unused_addr;

  assign reg_idx     = s_addr[7:3];
  assign unused_addr = ^{s_addr[15:8], s_addr[2:0]};
  assign wr_en       = s_sel & s_wr;

  always_comb begin
    we_start = 1'b0;
    we_clear = 1'b0;
    we_ien   = 1'b0;
    we_opnd  = 1'b0;
    if (wr_en) begin
      unique case (1'b1)
        (reg_idx == 5'd0): we_start = 1'b1;
        (reg_idx == 5'd1): we_clear = 1'b1;
        (reg_idx == 5'd3): we_ien   = 1'b1;
        (reg_idx == 5'd4): we_opnd  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      MUL:     opdone = 2'b10;
      DONE:    opdone = 2'b11;
      default: opdone = 2'b00;
    endcase
  end

  assign interrupt = intr_en_q & opdone[0];

  always_comb begin
    s_dout = 64'h0;
    if (s_sel && !s_wr) begin
      case (reg_idx)
        5'd0:    s_dout = {63'h0, opstart_q};
        5'd1:    s_dout = {63'h0, opclear_q};
        5'd2:    s_dout = {62'h0, opdone};
        5'd3:    s_dout = {63'h0, intr_en_q};
        5'd4:    s_dout = operand_q;
        5'd5:    s_dout = result_q[127:64];
        5'd6:    s_dout = result_q[63:0];
        default: s_dout = 64'h0;
      endcase
    end
  end

  assign cnt_dec = count_q - 64'd1;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (opclear_q) begin
      state_d  = IDLE;
      result_d = '0;
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (opstart_q) begin
            result_d = 128'd1;
            count_d  = operand_q;
            // first product is 1 * operand
            acc_d    = '0;
            mcand_d  = 128'd1;
            mplier_d = operand_q;
            state_d  = (operand_q <= 64'd1) ? DONE : MUL;
          end
        end
        MUL: begin
          if (mplier_q == 64'd0) begin
            result_d = acc_q;
            count_d  = cnt_dec;
            if (cnt_dec <= 64'd1) begin
              state_d = DONE;
            end else begin
              acc_d    = '0;
              mcand_d  = acc_q;
              mplier_d = cnt_dec;
            end
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opstart_q <= 1'b0;
      opclear_q <= 1'b0;
      intr_en_q <= 1'b0;
      operand_q <= '0;
    end else begin
      if (opclear_q)     opstart_q <= 1'b0;
      else if (we_start) opstart_q <= s_din[0];
      if (we_clear) opclear_q <= s_din[0];
      if (we_ien)   intr_en_q <= s_din[0];
      if (we_opnd && state_q != MUL) operand_q <= s_din;
    end
  end

endmodule

// File: tb/tb_facto_core.sv
// tb_facto_core: directed + random checks of facto_core against
// a plain factorial model.
module tb_facto_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int n_assert = 0;
  int n_fail   = 0;

  facto_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] A_START = 16'h00;
  localparam logic [15:0] A_CLEAR = 16'h08;
  localparam logic [15:0] A_DONE  = 16'h10;
  localparam logic [15:0] A_IEN   = 16'h18;
  localparam logic [15:0] A_OPND  = 16'h20;
  localparam logic [15:0] A_RESH  = 16'h28;
  localparam logic [15:0] A_RESL  = 16'h30;

  function automatic logic [127:0] fact(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= n; i++) r = r * 128'(i);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b1;
    s_addr = a;
    s_din  = d;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
    s_wr  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    s_sel  = 1'b1;
    s_wr   = 1'b0;
    s_addr = a;
    #1;
    d     = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    logic [63:0] d;
    for (int i = 0; i < limit; i++) begin
      rd(A_DONE, d);
      if (d[1:0] == 2'b11) break;
    end
  endtask

  task automatic clear_blk();
    wr(A_CLEAR, 64'd1);
    wr(A_CLEAR, 64'd0);
  endtask

  task automatic run_chk(input string tag, input int n, input int limit);
    logic [63:0]  lo, hi, d;
    logic [127:0] e;
    e = fact(n);
    clear_blk();
    wr(A_OPND, 64'(n));
    wr(A_START, 64'd1);
    wait_done(limit);
    rd(A_DONE, d);
    check({tag, "_done"}, 128'(d), 128'd3);
    rd(A_RESL, lo);
    rd(A_RESH, hi);
    check({tag, "_lo"}, 128'(lo), 128'(e[63:0]));
    check({tag, "_hi"}, 128'(hi), 128'(e[127:64]));
  endtask

  initial begin
    logic [63:0] d, lo, hi;
    int n;
    reset_n = 1'b0;
    s_sel   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_din   = '0;

    // reads during reset
    for (int a = 0; a < 8; a++) begin
      rd(16'(a * 8), d);
      check("rst_read", 128'(d), 128'd0);
    end
    check("rst_irq", 128'(interrupt), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(A_DONE, d);
    check("post_rst_done", 128'(d), 128'd0);

    // 3! with interrupt enabled
    wr(A_OPND, 64'd3);
    wr(A_IEN, 64'd1);
    wr(A_START, 64'd1);
    wait_done(200);
    rd(A_DONE, d);
    check("f3_done", 128'(d), 128'd3);
    check("f3_irq", 128'(interrupt), 128'd1);
    rd(A_RESL, lo);
    rd(A_RESH, hi);
    check("f3_lo", 128'(lo), 128'd6);
    check("f3_hi", 128'(hi), 128'd0);

    // opstart still held: no restart, result stable
    rd(A_START, d);
    check("held_start", 128'(d), 128'd1);
    repeat (20) @(posedge clk);
    rd(A_DONE, d);
    check("held_done", 128'(d), 128'd3);
    rd(A_RESL, lo);
    check("held_lo", 128'(lo), 128'd6);
    wr(A_START, 64'd0);
    wr(A_START, 64'd1);
    repeat (5) @(posedge clk);
    rd(A_DONE, d);
    check("restart_done", 128'(d), 128'd3);

    // opclear
    wr(A_CLEAR, 64'd1);
    @(posedge clk);
    rd(A_DONE, d);
    check("clr_done", 128'(d), 128'd0);
    rd(A_RESL, lo);
    check("clr_lo", 128'(lo), 128'd0);
    check("clr_irq", 128'(interrupt), 128'd0);
    rd(A_START, d);
    check("clr_start", 128'(d), 128'd0);
    rd(A_OPND, d);
    check("clr_opnd", 128'(d), 128'd3);
    rd(A_IEN, d);
    check("clr_ien", 128'(d), 128'd1);
    wr(A_CLEAR, 64'd0);
    repeat (3) @(posedge clk);
    rd(A_DONE, d);
    check("rel_idle", 128'(d), 128'd0);

    // 5!, MUL status visible
    wr(A_OPND, 64'd5);
    wr(A_START, 64'd1);
    @(posedge clk);
    rd(A_DONE, d);
    check("f5_mul", 128'(d), 128'd2);
    wait_done(500);
    rd(A_RESL, lo);
    check("f5_lo", 128'(lo), 128'd120);

    // 10!, operand write during MUL ignored
    clear_blk();
    wr(A_OPND, 64'd10);
    wr(A_START, 64'd1);
    @(posedge clk);
    wr(A_OPND, 64'd7);
    rd(A_OPND, d);
    check("mul_opnd", 128'(d), 128'd10);
    wait_done(500);
    rd(A_RESL, lo);
    check("f10_lo", 128'(lo), 128'd3628800);

    run_chk("f20", 20, 1000);
    rd(A_RESL, lo);
    check("f20_const", 128'(lo), 128'h21C3677C82B40000);

    // operand 1 and 0: DONE within 2 cycles
    for (int k = 1; k >= 0; k--) begin
      clear_blk();
      wr(A_OPND, 64'(k));
      wr(A_START, 64'd1);
      @(posedge clk);
      rd(A_DONE, d);
      check("small_done", 128'(d), 128'd3);
      rd(A_RESL, lo);
      check("small_lo", 128'(lo), 128'd1);
      check("small_irq", 128'(interrupt), 128'd1);
    end

    // interrupt masked; deselected read
    wr(A_IEN, 64'd0);
    rd(A_DONE, d);
    check("mask_done", 128'(d), 128'd3);
    check("mask_irq", 128'(interrupt), 128'd0);
    @(negedge clk);
    s_sel  = 1'b0;
    s_wr   = 1'b0;
    s_addr = A_RESL;
    #1;
    check("nosel_dout", 128'(s_dout), 128'd0);

    // address decode: upper bits ignored, unmapped 0, RO write ignored
    rd(16'hFF30, lo);
    check("hi_addr", 128'(lo), 128'd1);
    rd(16'h0038, d);
    check("unmapped", 128'(d), 128'd0);
    wr(A_RESL, 64'hDEAD);
    rd(A_RESL, lo);
    check("ro_write", 128'(lo), 128'd1);

    // random operands, overflow range included
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(0, 40));
      run_chk($sformatf("rnd%0d", n), n, 3000);
    end

    // reset mid-computation
    clear_blk();
    wr(A_IEN, 64'd1);
    wr(A_OPND, 64'd30);
    wr(A_START, 64'd1);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_irq", 128'(interrupt), 128'd0);
    rd(A_DONE, d);
    check("mid_rst_done", 128'(d), 128'd0);
    rd(A_OPND, d);
    check("mid_rst_opnd", 128'(d), 128'd0);
    rd(A_IEN, d);
    check("mid_rst_ien", 128'(d), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(A_RESL, lo);
    check("mid_rst_lo", 128'(lo), 128'd0);
    wr(A_OPND, 64'd4);
    wr(A_START, 64'd1);
    wait_done(300);
    rd(A_RESL, lo);
    check("after_rst_lo", 128'(lo), 128'd24);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
